// File: rtl/tribus_arbiter.sv
// tribus_arbiter: sequencing controller for one sn74ls441 tridirectional
// open-collector buffer shared by three bus owners A, B and C.
// Grants the buffer round-robin and drives its controls so that the source
// select is always set up with every output disabled, and every transfer
// ends in a turnaround gap. Two drivers therefore never fight on the buses.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   req[2:0]       source requests, bit0=A, bit1=B, bit2=C
//   dest_a/b/c     destination masks {C,B,A}; the source's own bit is ignored
//   gnt[2:0]       one-hot grant, high only during DRIVE
//   busy           high whenever the sequencer is not idle
//   done           one-cycle pulse on entry to TURN
//   cs             buffer chip select, active-low
//   s1, s0         source select: 00=A, 01=B, 10=C, 11=none
//   ga, gb, gc     per-port output enables, active-low
module tribus_arbiter #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned TURN_CYC  = 2,
    parameter int unsigned HOLD_MAX  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] dest_a,
    input  logic [2:0] dest_b,
    input  logic [2:0] dest_c,
    output logic [2:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       cs,
    output logic       s1,
    output logic       s0,
    output logic       ga,
    output logic       gb,
    output logic       gc
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRIVE = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       ptr;      // index of the highest-priority port
    logic [1:0]       win;      // latched winner index
    logic [2:0]       mask;     // latched destination mask, self bit cleared
    logic [CNT_W-1:0] cnt;      // cycles spent in the current state

    logic       found;
    logic [1:0] pick;
    logic [2:0] idx;
    logic [2:0] cand_dest;
    logic [2:0] cand_mask;

    // Round-robin scan starting at ptr, order A->B->C->A.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = 3'd0;
        for (int i = 0; i < 3; i++) begin
            idx = 3'(ptr) + 3'(i);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (!found && req[idx[1:0]]) begin
                found = 1'b1;
                pick  = idx[1:0];
            end
        end
    end

    // Destination mask of the candidate with its own bit forced to 0.
    always_comb begin
        case (pick)
            2'd0:    cand_dest = dest_a;
            2'd1:    cand_dest = dest_b;
            default: cand_dest = dest_c;
        endcase
        cand_mask = cand_dest & ~(3'b001 << pick);
    end

    // Sequencer; every output is assigned together with the state it belongs to.
    // Counters only increment while below their limit, so they cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            win   <= 2'd0;
            mask  <= 3'b000;
            cnt   <= '0;
            gnt   <= 3'b000;
            busy  <= 1'b0;
            done  <= 1'b0;
            cs    <= 1'b1;
            s1    <= 1'b1;
            s0    <= 1'b1;
            ga    <= 1'b1;
            gb    <= 1'b1;
            gc    <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A request whose only destination is itself is dropped
                    // for this cycle and re-evaluated on the next one.
                    if (found && (cand_mask != 3'b000)) begin
                        state    <= SETUP;
                        win      <= pick;
                        mask     <= cand_mask;
                        cnt      <= CNT_W'(1);
                        busy     <= 1'b1;
                        cs       <= 1'b0;
                        {s1, s0} <= pick;
                    end
                end
                SETUP: begin
                    if (cnt >= CNT_W'(SETUP_CYC)) begin
                        state        <= DRIVE;
                        cnt          <= CNT_W'(1);
                        gnt          <= 3'b001 << win;
                        {ga, gb, gc} <= {~mask[0], ~mask[1], ~mask[2]};
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (!req[win] || (cnt >= CNT_W'(HOLD_MAX))) begin
                        state        <= TURN;
                        cnt          <= CNT_W'(1);
                        gnt          <= 3'b000;
                        {ga, gb, gc} <= 3'b111;
                        done         <= 1'b1;
                        ptr          <= (win == 2'd2) ? 2'd0 : 2'(win + 2'd1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TURN: begin
                    if (cnt >= CNT_W'(TURN_CYC)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        cs    <= 1'b1;
                        s1    <= 1'b1;
                        s0    <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed bench for tribus_arbiter (SETUP_CYC=1, TURN_CYC=2, HOLD_MAX=4).
// Outputs are packed as {busy, done, cs, s1, s0, ga, gb, gc, gnt[2:0]}.
module tb_tribus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] dest_a;
    logic [2:0] dest_b;
    logic [2:0] dest_c;
    logic [2:0] gnt;
    logic       busy;
    logic       done;
    logic       cs;
    logic       s1;
    logic       s0;
    logic       ga;
    logic       gb;
    logic       gc;

    int n_tests = 0;
    int n_fail  = 0;

    tribus_arbiter #(
        .SETUP_CYC(1),
        .TURN_CYC (2),
        .HOLD_MAX (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .dest_a(dest_a),
        .dest_b(dest_b),
        .dest_c(dest_c),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .cs    (cs),
        .s1    (s1),
        .s0    (s0),
        .ga    (ga),
        .gb    (gb),
        .gc    (gc)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ex(input logic b, input logic d, input logic c,
                                       input logic [1:0] s, input logic [2:0] g,
                                       input logic [2:0] gn);
        return {b, d, c, s, g, gn};
    endfunction

    function automatic logic [10:0] snap();
        return {busy, done, cs, s1, s0, ga, gb, gc, gnt};
    endfunction

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (busy,done,cs,s1,s0,ga,gb,gc,gnt)", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    localparam logic [10:0] IDLE_V = 11'b0_0_1_11_111_000;

    logic [1:0] ord  [4];
    logic [2:0] gtab [3];
    logic [2:0] w_gnt;

    initial begin
        ord  = '{2'd0, 2'd1, 2'd2, 2'd0};
        gtab = '{3'b100, 3'b010, 3'b001};
        rst = 1'b1; req = 3'b000; dest_a = 3'b000; dest_b = 3'b000; dest_c = 3'b000;

        // Reset, then idle for 10 cycles.
        tick();
        check("reset", snap(), IDLE_V);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle", snap(), IDLE_V);
        end

        // Single A transfer to B and C.
        req = 3'b001; dest_a = 3'b110;
        tick(); check("a_setup", snap(), ex(1, 0, 0, 2'b00, 3'b111, 3'b000));
        tick(); check("a_drive", snap(), ex(1, 0, 0, 2'b00, 3'b100, 3'b001));
        tick(); check("a_drive2", snap(), ex(1, 0, 0, 2'b00, 3'b100, 3'b001));
        req = 3'b000;
        tick(); check("a_turn1", snap(), ex(1, 1, 0, 2'b00, 3'b111, 3'b000));
        tick(); check("a_turn2", snap(), ex(1, 0, 0, 2'b00, 3'b111, 3'b000));
        tick(); check("a_idle", snap(), IDLE_V);

        // All three requesting: rotate A,B,C,A with HOLD_MAX forced release.
        do_reset();
        check("rot_reset", snap(), IDLE_V);
        req = 3'b111; dest_a = 3'b110; dest_b = 3'b101; dest_c = 3'b011;
        for (int k = 0; k < 4; k++) begin
            w_gnt = 3'b001 << ord[k];
            tick(); check("rot_setup", snap(), ex(1, 0, 0, ord[k], 3'b111, 3'b000));
            for (int j = 0; j < 4; j++) begin
                tick(); check("rot_drive", snap(), ex(1, 0, 0, ord[k], gtab[ord[k]], w_gnt));
            end
            tick(); check("rot_turn1", snap(), ex(1, 1, 0, ord[k], 3'b111, 3'b000));
            tick(); check("rot_turn2", snap(), ex(1, 0, 0, ord[k], 3'b111, 3'b000));
            tick(); check("rot_idle", snap(), IDLE_V);
        end
        req = 3'b000;

        // Self-only destination stays idle until the mask is fixed.
        do_reset();
        req = 3'b010; dest_b = 3'b010;
        tick(); check("self_idle1", snap(), IDLE_V);
        tick(); check("self_idle2", snap(), IDLE_V);
        dest_b = 3'b100;
        tick(); check("b_setup", snap(), ex(1, 0, 0, 2'b01, 3'b111, 3'b000));
        tick(); check("b_drive", snap(), ex(1, 0, 0, 2'b01, 3'b110, 3'b010));
        dest_b = 3'b001;
        tick(); check("b_mask_held", snap(), ex(1, 0, 0, 2'b01, 3'b110, 3'b010));
        req = 3'b000;
        tick(); check("b_turn1", snap(), ex(1, 1, 0, 2'b01, 3'b111, 3'b000));
        tick(); tick(); check("b_idle", snap(), IDLE_V);

        // Reset during DRIVE, then pointer is back at A.
        req = 3'b100; dest_c = 3'b011;
        tick(); check("c_setup", snap(), ex(1, 0, 0, 2'b10, 3'b111, 3'b000));
        tick(); check("c_drive", snap(), ex(1, 0, 0, 2'b10, 3'b001, 3'b100));
        rst = 1'b1;
        tick(); check("c_rst", snap(), IDLE_V);
        rst = 1'b0;
        req = 3'b101; dest_a = 3'b110;
        tick(); check("ptr_a_setup", snap(), ex(1, 0, 0, 2'b00, 3'b111, 3'b000));
        tick(); check("ptr_a_drive", snap(), ex(1, 0, 0, 2'b00, 3'b100, 3'b001));
        req = 3'b000;
        tick(); check("ptr_a_turn1", snap(), ex(1, 1, 0, 2'b00, 3'b111, 3'b000));
        tick(); tick(); check("ptr_a_idle", snap(), IDLE_V);

        // A drops its request during SETUP: one DRIVE cycle, then TURN.
        req = 3'b001; dest_a = 3'b010;
        tick(); check("drop_setup", snap(), ex(1, 0, 0, 2'b00, 3'b111, 3'b000));
        req = 3'b000;
        tick(); check("drop_drive", snap(), ex(1, 0, 0, 2'b00, 3'b101, 3'b001));
        tick(); check("drop_turn1", snap(), ex(1, 1, 0, 2'b00, 3'b111, 3'b000));
        tick(); check("drop_turn2", snap(), ex(1, 0, 0, 2'b00, 3'b111, 3'b000));
        tick(); check("drop_idle", snap(), IDLE_V);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tribus_arbiter.md
Name: tribus_arbiter

Overview:
- Sequencing controller for one sn74ls441 tridirectional inverting open-collector buffer shared by three bus owners (A, B, C).
- Arbitrates source requests round-robin and drives the buffer controls: cs (active-low), s1/s0 (source select: 00=A, 01=B, 10=C, 11=none) and ga/gb/gc (active-low per-port output enables).
- Enforces break-before-make: source select is set up with all outputs disabled, and every transfer ends in a turnaround gap, so two drivers never fight on the open-collector buses.

Parameters:
- SETUP_CYC, 1, cycles with select valid and all outputs disabled before the enables assert (1..15).
- TURN_CYC, 2, cycles with all outputs disabled after a transfer ends (1..15).
- HOLD_MAX, 16, maximum DRIVE cycles per grant before forced release (1..255).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- req  input  3  source requests; bit0=A, bit1=B, bit2=C.
- dest_a  input  3  destination mask {C,B,A} used when A is the source; the A bit is ignored.
- dest_b  input  3  destination mask used when B is the source; the B bit is ignored.
- dest_c  input  3  destination mask used when C is the source; the C bit is ignored.
- gnt  output  3  one-hot grant; high only during DRIVE.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on entry to TURN.
- cs  output  1  buffer chip select, active-low.
- s1  output  1  source select, high bit.
- s0  output  1  source select, low bit.
- ga  output  1  A output enable, active-low.
- gb  output  1  B output enable, active-low.
- gc  output  1  C output enable, active-low.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, cs=1, s1s0=11, ga=gb=gc=1, gnt=000, busy=0, done=0. The round-robin pointer resets to A (A has highest priority).
- IDLE: cs=1, s=11, all g=1.
  - If req≠0, pick the first set bit scanning from the pointer in order A→B→C→A.
  - Latch the winner and its dest mask, with the self bit forced to 0.
  - If the latched mask is 0, drop the request for this cycle and stay in IDLE; it is re-evaluated next cycle.
  - Otherwise go to SETUP.
- SETUP: cs=0, s=winner code, all g=1, for SETUP_CYC cycles, then go to DRIVE.
- DRIVE:
  - cs=0 and s held.
  - g for each port in the latched mask = 0; all other g = 1.
  - gnt bit for the winner = 1.
  - Exit to TURN when the winner's req drops, or when HOLD_MAX DRIVE cycles have elapsed, whichever comes first.
  - Mask changes during DRIVE are ignored.
- TURN:
  - All g=1 and gnt=0 on the first TURN cycle; cs=0 and s held.
  - done=1 on the first TURN cycle only.
  - Lasts TURN_CYC cycles, then IDLE.
  - The pointer advances to the port after the winner at TURN entry.
- Latency: req asserted in IDLE → gnt high after 1+SETUP_CYC cycles (default 2).
- Only one source is ever selected; gnt is never high while the s or g outputs are changing.
- Requests arriving from other ports during SETUP/DRIVE/TURN are held off until IDLE.
- Winner drops req during SETUP: still go through DRIVE for exactly 1 cycle, then TURN. The sequence is never aborted mid-setup.
- Forced release by HOLD_MAX: if the winner is still requesting, the pointer has already moved past it, so it regains the bus only when the other ports are idle.
- rst asserted in any state: next edge returns to reset values; the outputs disable in the same cycle with no turnaround.
- Counters saturate and never wrap within a state.

Test Plan:
- Reset then idle, req=000 → cs=1, s1s0=11, gagbgc=111, gnt=000 for 10 cycles.
- req=001, dest_a=110: SETUP_CYC cycles with cs=0, s=00, g=111; then g=100, gnt=001. Drop req: g=111, done pulse, TURN_CYC cycles, then IDLE.
- req=111 held continuously, HOLD_MAX=4 → grants rotate A,B,C,A; each DRIVE lasts 4 cycles; s sequence 00,01,10; no cycle has two g changes without an all-111 cycle between them.
- req=010, dest_b=010 (self only) → stays in IDLE, cs=1. Change to dest_b=100: next cycle SETUP with s=01, then DRIVE with g=110.
- req=100, dest_c=011; rst pulsed during DRIVE → next edge cs=1, s=11, g=111, gnt=000, busy=0, pointer back at A.
- Winner A drops req during SETUP → exactly one DRIVE cycle with gnt=001, then done=1 and TURN.
